// File: rtl/div_4bits.sv
// Sequential restoring shift/subtract unsigned divider: one quotient bit per clock.
// Optional macro DIV_BYZERO_EARLY_EN: a zero divisor completes at once and raises div_zero_o.
module div_4bits #(
    parameter int bits = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [bits-1:0] A,
    input  logic [bits-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [bits-1:0] Quotient_o,
    output logic [bits-1:0] Remainder_o,
    output logic            div_zero_o
);

    localparam int CW = $clog2(bits + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [bits-1:0] dvd;
    logic [bits-1:0] dvs;
    logic [bits-1:0] quot;
    logic [bits:0]   rem;
    logic [CW-1:0]   cnt;

    logic [bits:0]   shifted;
    logic            ge;
    logic [bits:0]   rem_next;
    logic [bits-1:0] quot_next;
    logic            early_zero;

    // Protocol: start is taken only in IDLE (busy low); A/B are captured on that
    // edge. done pulses one cycle with the results, and that cycle is IDLE again.
    always_comb begin
        shifted   = (rem << 1) | {{bits{1'b0}}, dvd[bits-1]};
        ge        = (shifted >= {1'b0, dvs});
        rem_next  = ge ? (shifted - {1'b0, dvs}) : shifted;
        quot_next = (quot << 1) | {{(bits-1){1'b0}}, ge};
`ifdef DIV_BYZERO_EARLY_EN
        early_zero = (B == '0);
`else
        early_zero = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            Quotient_o  <= '0;
            Remainder_o <= '0;
            dvd         <= '0;
            dvs         <= '0;
            quot        <= '0;
            rem         <= '0;
            cnt         <= '0;
`ifdef DIV_BYZERO_EARLY_EN
            div_zero_o  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (early_zero) begin
                            done        <= 1'b1;
                            Quotient_o  <= '1;
                            Remainder_o <= A;
`ifdef DIV_BYZERO_EARLY_EN
                            div_zero_o  <= 1'b1;
`endif
                        end else begin
                            dvd   <= A;
                            dvs   <= B;
                            rem   <= '0;
                            quot  <= '0;
                            cnt   <= CW'(bits);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem  <= rem_next;
                    quot <= quot_next;
                    dvd  <= dvd << 1;
                    cnt  <= cnt - CW'(1);
                    // Final step: publish the just-computed bit directly, not the stale register.
                    if (cnt == CW'(1)) begin
                        Quotient_o  <= quot_next;
                        Remainder_o <= rem_next[bits-1:0];
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
`ifdef DIV_BYZERO_EARLY_EN
                        div_zero_o  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef DIV_BYZERO_EARLY_EN
    assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_div_4bits.sv
// Self-checking bench for div_4bits: directed scenarios, exhaustive sweep and random divisions.
module tb_div_4bits;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Quotient_o;
  logic [W-1:0] Remainder_o;
  logic         div_zero_o;

  int checks = 0;
  int errors = 0;

  // expected {div_zero, quotient, remainder}
  logic [2*W:0] exp_q[$];

  div_4bits #(.bits(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .Quotient_o(Quotient_o),
    .Remainder_o(Remainder_o),
    .div_zero_o(div_zero_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic bit early_mode();
`ifdef DIV_BYZERO_EARLY_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // reference model: plain integer division, zero divisor gives all-ones / A
  function automatic logic [2*W:0] model(input int a, input int b);
    int q, r;
    logic dz;
    if (b == 0) begin
      q  = (1 << W) - 1;
      r  = a;
      dz = early_mode();
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end
    return {dz, W'(q), W'(r)};
  endfunction

  function automatic int exp_latency(input int b);
    return (b == 0 && early_mode()) ? 0 : W;
  endfunction

  // driver: present operands with start for one edge, then scramble inputs
  task automatic issue(input int a, input int b);
    start = 1'b1;
    A = W'(a);
    B = W'(b);
    exp_q.push_back(model(a, b));
    tick();
    start = 1'b0;
    A = W'($urandom_range(0, 15));
    B = W'($urandom_range(0, 15));
  endtask

  task automatic wait_done(input string name, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: done=%b after %0d cycles, required 1", name, done, lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done: busy=%b required 0", name, busy);
    end
  endtask

  // scoreboard: compare outputs in the done cycle with the oldest expectation
  task automatic check_result(input string name);
    logic [2*W:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: got q=%0d r=%0d with no expectation", name, Quotient_o, Remainder_o);
    end else begin
      e = exp_q.pop_front();
      if (Quotient_o !== e[2*W-1:W]) begin
        errors++;
        $display("FAIL %s quotient: got %0d required %0d", name, Quotient_o, e[2*W-1:W]);
      end
      checks++;
      if (Remainder_o !== e[W-1:0]) begin
        errors++;
        $display("FAIL %s remainder: got %0d required %0d", name, Remainder_o, e[W-1:0]);
      end
      checks++;
      if (div_zero_o !== e[2*W]) begin
        errors++;
        $display("FAIL %s div_zero: got %b required %b", name, div_zero_o, e[2*W]);
      end
    end
  endtask

  task automatic check_timing(input string name, input int lat, input int busy_cnt, input int b);
    checks++;
    if (lat != exp_latency(b)) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_latency(b));
    end
    checks++;
    if (busy_cnt != exp_latency(b)) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, exp_latency(b));
    end
  endtask

  // full single division, then confirm done drops and results hold
  task automatic run_div(input string name, input int a, input int b);
    int lat, bc;
    logic [W-1:0] q_seen, r_seen;
    issue(a, b);
    wait_done(name, lat, bc);
    check_timing(name, lat, bc, b);
    check_result(name);
    q_seen = Quotient_o;
    r_seen = Remainder_o;
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse_width: done=%b one cycle later, required 0", name, done);
    end
    checks++;
    if (Quotient_o !== q_seen || Remainder_o !== r_seen) begin
      errors++;
      $display("FAIL %s result_hold: got q=%0d r=%0d required q=%0d r=%0d", name, Quotient_o, Remainder_o, q_seen, r_seen);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, Quotient_o, Remainder_o, div_zero_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d dz=%b required all 0", busy, done, Quotient_o, Remainder_o, div_zero_o);
    end
  endtask

  task automatic test_basic();
    run_div("basic_13_3", 13, 3);
    run_div("basic_7_7", 7, 7);
    run_div("basic_3_9", 3, 9);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(15, 1);
    wait_done("b2b_first", lat, bc);
    check_timing("b2b_first", lat, bc, 1);
    check_result("b2b_first");
    issue(5, 7);
    wait_done("b2b_second", lat, bc);
    check_timing("b2b_second", lat, bc, 7);
    check_result("b2b_second");
    tick();
  endtask

  task automatic test_div_zero();
    run_div("div_zero_9_0", 9, 0);
    run_div("div_zero_0_0", 0, 0);
  endtask

  task automatic test_start_ignored();
    int n, extra;
    issue(12, 5);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (n == 1) begin
        start = 1'b1;
        A = 4'd2;
        B = 4'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    checks++;
    if (n != W) begin
      errors++;
      $display("FAIL ignore_start latency: got %0d required %0d", n, W);
    end
    check_result("ignore_start");
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_start extra_activity: got %0d busy/done cycles required 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    issue(14, 4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if ({busy, done, Quotient_o, Remainder_o, div_zero_o} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b done=%b q=%0d r=%0d dz=%b required all 0", busy, done, Quotient_o, Remainder_o, div_zero_o);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d busy/done cycles required 0", seen);
    end
    run_div("abort_restart", 14, 4);
  endtask

  task automatic test_exhaustive();
    int bad;
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div("exhaustive", a, b);
        if (int'(Quotient_o) * b + int'(Remainder_o) != a || int'(Remainder_o) >= b) begin
          bad++;
          $display("FAIL exhaustive_identity: a=%0d b=%0d got q=%0d r=%0d", a, b, Quotient_o, Remainder_o);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL exhaustive_summary: got %0d identity violations required 0", bad);
    end
  endtask

  task automatic test_random();
    int a, b, gap;
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      run_div("random", a, b);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_exhaustive();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
